// File: rtl/dr_fifo.sv
// Synchronous FIFO with valid/ready handshakes, flush, occupancy count and almost-full flag.
// The head word is held in a register so out_* never depends combinationally on in_*.
module dr_fifo #(
    parameter int unsigned     WIDTH     = 16,
    parameter int unsigned     DEPTH     = 4,
    parameter int unsigned     AF_LEVEL  = DEPTH - 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    input  logic                         flush,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         almost_full
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             af_q, af_d;
    logic             push_c, pop_c;

    assign in_ready = (count_q != CW'(DEPTH)) && !flush;

    // Next-state: pointers, occupancy and the registered head/last-dequeued word.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        out_data_d = out_data_q;
        push_c     = in_valid && in_ready;
        pop_c      = out_valid_q && out_ready && !flush;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_c) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop_c)  rd_ptr_d = rd_ptr_q + PW'(1);
            if (push_c && !pop_c)      count_d = count_q + CW'(1);
            else if (pop_c && !push_c) count_d = count_q - CW'(1);
            // New head comes from the incoming word when it lands in the head slot;
            // when the queue drains, the last dequeued word simply stays put.
            if (count_d != '0) begin
                if (push_c && (rd_ptr_d == wr_ptr_q)) out_data_d = in_data;
                else                                  out_data_d = mem_q[rd_ptr_d];
            end
        end

        out_valid_d = (count_d != '0);
        af_d        = (32'(count_d) >= AF_LEVEL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_data_q  <= RESET_VAL;
            out_valid_q <= 1'b0;
            af_q        <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            af_q        <= af_d;
        end
    end

    // Storage array is never reset; stale contents are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (push_c) mem_q[wr_ptr_q] <= in_data;
    end

    assign count       = count_q;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign almost_full = af_q;

endmodule

// File: tb/tb_dr_fifo.sv
// Directed bench for dr_fifo: a queue scoreboard predicts head data, count and flags each cycle.
module tb_dr_fifo;

    localparam int unsigned W  = 16;
    localparam int unsigned D  = 4;
    localparam int unsigned CW = $clog2(D + 1);

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          flush;
    logic [CW-1:0] count;
    logic          almost_full;

    logic [W-1:0]  sb [$];
    logic [W-1:0]  exp_out;
    int            checks;
    int            errors;

    dr_fifo #(.WIDTH(W), .DEPTH(D)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .flush       (flush),
        .count       (count),
        .almost_full (almost_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus; model decides accept/pop, then outputs are compared after the edge.
    task automatic cycle(input logic iv, input logic [W-1:0] id, input logic ordy, input logic fl);
        bit          push;
        bit          pop;
        int unsigned n;
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        flush     = fl;
        n         = sb.size();
        #1;
        check("in_ready", 32'(in_ready), 32'((n != D) && !fl));
        push = iv && (n != D) && !fl;
        pop  = (n != 0) && ordy && !fl;
        @(posedge clk);
        #1;
        if (fl) begin
            sb.delete();
        end else begin
            if (pop)  exp_out = sb.pop_front();
            if (push) sb.push_back(id);
        end
        if (sb.size() != 0) exp_out = sb[0];
        check("count",       32'(count),       32'(sb.size()));
        check("out_valid",   32'(out_valid),   32'(sb.size() != 0));
        check("out_data",    32'(out_data),    32'(exp_out));
        check("almost_full", 32'(almost_full), 32'(sb.size() >= D - 1));
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        exp_out   = '0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        flush     = 1'b0;

        // Reset state, no traffic
        #12;
        check("rst_out_valid",   32'(out_valid),   32'd0);
        check("rst_in_ready",    32'(in_ready),    32'd1);
        check("rst_count",       32'(count),       32'd0);
        check("rst_out_data",    32'(out_data),    32'h0000);
        check("rst_almost_full", 32'(almost_full), 32'd0);
        #1 rst_n = 1'b1;

        // Fill to full, fifth offer refused, then drain in order
        for (int i = 0; i < 4; i++) cycle(1'b1, W'(16'h1111 * (i + 1)), 1'b0, 1'b0);
        cycle(1'b1, 16'h5555, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, W'($urandom), 1'b1, 1'b0);

        // Pops on empty are ignored
        cycle(1'b0, W'($urandom), 1'b1, 1'b0);
        cycle(1'b0, W'($urandom), 1'b1, 1'b0);

        // Steady push+pop at count=2 across pointer wrap
        cycle(1'b1, 16'hBBB1, 1'b0, 1'b0);
        cycle(1'b1, 16'hBBB2, 1'b0, 1'b0);
        for (int i = 0; i < 2 * D; i++) cycle(1'b1, W'(16'hAAAA + i), 1'b1, 1'b0);
        cycle(1'b0, W'($urandom), 1'b1, 1'b0);
        cycle(1'b0, W'($urandom), 1'b1, 1'b0);

        // Push+pop at count=DEPTH-1, then at full only the pop happens
        for (int i = 0; i < 3; i++) cycle(1'b1, W'(16'hC001 + i), 1'b0, 1'b0);
        cycle(1'b1, 16'hC004, 1'b1, 1'b0);
        cycle(1'b1, 16'hC005, 1'b0, 1'b0);
        cycle(1'b1, 16'hC006, 1'b1, 1'b0);
        for (int i = 0; i < D; i++) cycle(1'b0, W'($urandom), 1'b1, 1'b0);

        // Push+pop at count=1
        cycle(1'b1, 16'hD001, 1'b0, 1'b0);
        cycle(1'b1, 16'hD002, 1'b1, 1'b0);
        cycle(1'b0, W'($urandom), 1'b1, 1'b0);

        // Last word stays visible after draining; in_data wiggles are ignored
        cycle(1'b1, 16'h5A5A, 1'b0, 1'b0);
        cycle(1'b0, W'($urandom), 1'b1, 1'b0);
        cycle(1'b0, W'($urandom), 1'b1, 1'b0);
        cycle(1'b0, W'($urandom), 1'b1, 1'b0);

        // Flush with count=3 and a concurrent push
        for (int i = 0; i < 3; i++) cycle(1'b1, W'(16'hE001 + i), 1'b0, 1'b0);
        cycle(1'b1, 16'hEEEE, 1'b1, 1'b1);
        cycle(1'b1, 16'hF001, 1'b0, 1'b0);
        cycle(1'b0, W'($urandom), 1'b1, 1'b0);

        // Asynchronous reset between edges with count=2
        cycle(1'b1, 16'h1234, 1'b0, 1'b0);
        cycle(1'b1, 16'h5678, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arst_count",       32'(count),       32'd0);
        check("arst_out_valid",   32'(out_valid),   32'd0);
        check("arst_almost_full", 32'(almost_full), 32'd0);
        check("arst_out_data",    32'(out_data),    32'h0000);
        #1 rst_n = 1'b1;
        sb.delete();
        exp_out = '0;
        cycle(1'b1, 16'h9999, 1'b0, 1'b0);
        cycle(1'b0, W'($urandom), 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
